// File: rtl/bmp_draw_sequencer.sv
// bmp_draw_sequencer
// Memory-mapped draw-command queue and issue sequencer for the BMP/font
// placement engine. The CPU writes X, Y and CMD registers; every CMD write
// pushes {x, y, img/fnt, indx} into a circular FIFO. A small FSM hands one
// command at a time to the engine with a single-cycle add_img/add_fnt pulse,
// then follows the engine's busy handshake (with a timeout on the rising edge).
// Optional build macro: BMP_SEQ_AUTOADV_EN (font pushes advance Xreg by FONT_W).
module bmp_draw_sequencer #(
  parameter logic [15:0] BASE_ADDR   = 16'hC008,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [9:0]  FONT_W      = 10'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bmp_sel,
  input  logic [15:0] addr,
  input  logic [15:0] databus,
  output logic [15:0] status,
  input  logic        plc_busy,
  output logic        add_img,
  output logic        add_fnt,
  output logic [4:0]  image_indx,
  output logic [5:0]  fnt_indx,
  output logic [9:0]  xloc,
  output logic [8:0]  yloc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ZERO   = {(AW + 1){1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(ACK_TIMEOUT);
  localparam logic [15:0]   STATUS_RST = 16'h0004;

  // One queued draw command; 26 bits wide.
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       img;
    logic [5:0] idx;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Pointers carry one extra MSB: equal low bits with differing MSB means full.
  function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  function automatic logic ptr_empty(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr == rd);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          add_img_q, add_img_d;
  logic          add_fnt_q, add_fnt_d;
  logic [9:0]    xloc_q, xloc_d;
  logic [8:0]    yloc_q, yloc_d;
  logic [4:0]    img_idx_q, img_idx_d;
  logic [5:0]    fnt_idx_q, fnt_idx_d;
  logic          err_to_q, err_to_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    xreg_q, xreg_d;
  logic [8:0]    yreg_q, yreg_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   status_q, status_d;
  entry_t        fifo_mem_q [FIFO_DEPTH];

  logic   sel_x_s, sel_y_s, sel_cmd_s, sel_stat_s;
  logic   fifo_empty_s, fifo_full_s;
  logic   pop_s, push_ok_s;
  entry_t cmd_entry_s, head_s;
  logic   unused_bits_s;

  // Bus decode: one strobe per register slot.
  always_comb begin
    sel_x_s    = bmp_sel && (addr == BASE_ADDR);
    sel_y_s    = bmp_sel && (addr == (BASE_ADDR + 16'd1));
    sel_cmd_s  = bmp_sel && (addr == (BASE_ADDR + 16'd2));
    sel_stat_s = bmp_sel && (addr == (BASE_ADDR + 16'd3));
  end

  assign unused_bits_s = ^databus[15:10];

  // FIFO flags, head entry and the entry a CMD write would push (uses pre-write X/Y).
  always_comb begin
    fifo_empty_s = ptr_empty(wr_ptr_q, rd_ptr_q);
    fifo_full_s  = ptr_full(wr_ptr_q, rd_ptr_q);
    head_s       = fifo_mem_q[rd_ptr_q[AW-1:0]];
    cmd_entry_s  = '{x: xreg_q, y: yreg_q, img: databus[0], idx: databus[6:1]};
    pop_s        = (state_q == S_ISSUE);
    push_ok_s    = sel_cmd_s && (!fifo_full_s || pop_s);
  end

  // X/Y position registers, with optional glyph auto-advance on accepted font pushes.
  always_comb begin
    xreg_d = xreg_q;
    yreg_d = yreg_q;
    if (sel_x_s) begin
      xreg_d = databus[9:0];
    end
`ifdef BMP_SEQ_AUTOADV_EN
    else if (push_ok_s && !databus[0]) begin
      xreg_d = xreg_q + FONT_W;
    end
`endif
    else begin
      xreg_d = xreg_q;
    end
    if (sel_y_s) begin
      yreg_d = databus[8:0];
    end else begin
      yreg_d = yreg_q;
    end
  end

  // FIFO pointer advance and the sticky overflow flag (a full push survives only alongside a pop).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (sel_cmd_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (sel_stat_s && databus[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Issue FSM next state; issue outputs are loaded on the edge into ISSUE so they are registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_img_d = 1'b0;
    add_fnt_d = 1'b0;
    xloc_d    = xloc_q;
    yloc_d    = yloc_q;
    img_idx_d = img_idx_q;
    fnt_idx_d = fnt_idx_q;
    if (sel_stat_s && databus[4]) begin
      err_to_d = 1'b0;
    end else begin
      err_to_d = err_to_q;
    end
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && !plc_busy) begin
          state_d   = S_ISSUE;
          add_img_d = head_s.img;
          add_fnt_d = !head_s.img;
          xloc_d    = head_s.x;
          yloc_d    = head_s.y;
          img_idx_d = head_s.idx[4:0];
          fnt_idx_d = head_s.idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT_ACK: begin
        if (plc_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q <= CNT_ONE) begin
          state_d  = S_IDLE;
          cnt_d    = CNT_ZERO;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (!plc_busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status word assembled from next-state values so the registered copy is current.
  always_comb begin
    status_d = {10'b0, err_to_d, ovf_d, ptr_full(wr_ptr_d, rd_ptr_d),
                ptr_empty(wr_ptr_d, rd_ptr_d), (state_d != S_IDLE), 1'b0};
  end

  // FSM state, timeout counter and all issue-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      add_img_q <= 1'b0;
      add_fnt_q <= 1'b0;
      xloc_q    <= 10'd0;
      yloc_q    <= 9'd0;
      img_idx_q <= 5'd0;
      fnt_idx_q <= 6'd0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_img_q <= add_img_d;
      add_fnt_q <= add_fnt_d;
      xloc_q    <= xloc_d;
      yloc_q    <= yloc_d;
      img_idx_q <= img_idx_d;
      fnt_idx_q <= fnt_idx_d;
      err_to_q  <= err_to_d;
    end
  end

  // Register file, FIFO pointers, overflow flag and status word.
  always_ff @(posedge clk) begin
    if (rst) begin
      xreg_q   <= 10'd0;
      yreg_q   <= 9'd0;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      ovf_q    <= 1'b0;
      status_q <= STATUS_RST;
    end else begin
      xreg_q   <= xreg_d;
      yreg_q   <= yreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
    end
  end

  // FIFO storage; contents are meaningless until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= cmd_entry_s;
    end
  end

  assign status     = status_q;
  assign add_img    = add_img_q;
  assign add_fnt    = add_fnt_q;
  assign image_indx = img_idx_q;
  assign fnt_indx   = fnt_idx_q;
  assign xloc       = xloc_q;
  assign yloc       = yloc_q;

endmodule
